// File: rtl/mul_seq_if.sv
// Execute-stage multiply sequencer bus: issue operands, pipeline writeback
// request and the arbitrated register-file write port plus hazard status.
interface mul_seq_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             StartE;
    logic             AccE;
    logic             FlushE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic [WIDTH-1:0] SrcCE;
    logic [AW-1:0]    WA3E;
    logic             RegWriteW;
    logic [AW-1:0]    WA3W;
    logic [WIDTH-1:0] ResultW;
    logic             StallMul;
    logic             PendValid;
    logic [AW-1:0]    PendWA;
    logic             RegWriteRF;
    logic [AW-1:0]    WA3RF;
    logic [WIDTH-1:0] WD3RF;
    logic             MulDone;

    // Pipeline side: drives issue and writeback, observes port and status
    modport master (
        output StartE, AccE, FlushE, SrcAE, SrcBE, SrcCE, WA3E,
        output RegWriteW, WA3W, ResultW,
        input  StallMul, PendValid, PendWA, RegWriteRF, WA3RF, WD3RF, MulDone
    );

    // Sequencer side
    modport slave (
        input  StartE, AccE, FlushE, SrcAE, SrcBE, SrcCE, WA3E,
        input  RegWriteW, WA3W, ResultW,
        output StallMul, PendValid, PendWA, RegWriteRF, WA3RF, WD3RF, MulDone
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Iterative shift-add MUL/MLA sequencer for the execute stage.
// One multiplier bit per RUN cycle, early exit once the remaining multiplier
// is zero. Owns the register-file write port only in WB when the pipeline
// writeback is idle; the pipeline always wins a collision.
//
// state | meaning
// IDLE  | waiting for an unflushed StartE
// RUN   | shift-add one multiplier bit per cycle
// WB    | result ready, waiting for a free write port
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input logic   clk,
    input logic   reset,
    mul_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic [AW-1:0]    dest;

    logic             accept;
    logic             wbGo;
    logic             lastBit;
    logic [WIDTH-1:0] accNext;
    logic [WIDTH-1:0] mplierNext;
    logic             busy;

    // Issue qualification, next partial sum and exit condition
    always_comb begin
        accept     = (state == IDLE) && bus.StartE && !bus.FlushE;
        mplierNext = mplier >> 1;
        accNext    = mplier[0] ? (acc + mcand) : acc;
        lastBit    = (mplierNext == '0) || (count == CW'(WIDTH - 1));
        wbGo       = (state == WB) && !bus.RegWriteW;
        busy       = (state == RUN) || (state == WB);
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            dest   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= bus.SrcAE;
                        mplier <= bus.SrcBE;
                        acc    <= bus.AccE ? bus.SrcCE : '0;
                        dest   <= bus.WA3E;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= accNext;
                    mcand  <= mcand << 1;
                    mplier <= mplierNext;
                    count  <= count + 1'b1;
                    if (lastBit) state <= WB;
                end
                WB: begin
                    if (wbGo) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-port mux; reset low suppresses every register-file write
    always_comb begin
        if (wbGo) begin
            bus.RegWriteRF = reset;
            bus.WA3RF      = dest;
            bus.WD3RF      = acc;
        end else begin
            bus.RegWriteRF = reset && bus.RegWriteW;
            bus.WA3RF      = bus.WA3W;
            bus.WD3RF      = bus.ResultW;
        end
    end

    // Hazard-unit status
    always_comb begin
        bus.StallMul  = busy;
        bus.PendValid = busy;
        bus.PendWA    = busy ? dest : '0;
        bus.MulDone   = wbGo;
    end
endmodule
